// File: rtl/lsu_align_sequencer.sv
// Load/store sequencer in front of the unified byte memory: yields to fetch slots, splits
// misaligned halfword/word accesses into byte beats and reassembles load data.
module lsu_align_sequencer #(
   parameter int unsigned ADDR_W      = 9,
   parameter bit          MISALIGN_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_slot,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_funct3,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   localparam logic [2:0] F3B  = 3'b000;
   localparam logic [2:0] F3H  = 3'b001;
   localparam logic [2:0] F3W  = 3'b010;
   localparam logic [2:0] F3BU = 3'b100;
   localparam logic [2:0] F3HU = 3'b101;

   state_e              state_q, state_d;
   logic                we_q;
   logic [2:0]          funct3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                split_q;
   logic                err_q;
   logic [2:0]          beats_q;
   logic [2:0]          idx_q;
   logic [31:0]         asm_q;

   logic                accept;
   logic                legal;
   logic                misaligned;
   logic                err_req;
   logic [2:0]          beats_req;
   logic                beat_fire;
   logic                last_beat;
   logic [31:0]         load_result;

   assign accept    = req_valid && (state_q == StIdle);
   assign beat_fire = (state_q == StAccess) && !fetch_slot;
   assign last_beat = (idx_q == (beats_q - 3'd1));

   // Request decode: legality, misalignment and beat count.
   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         F3B, F3H, F3W: legal = 1'b1;
         F3BU, F3HU:    legal = !req_we;
         default:       legal = 1'b0;
      endcase
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      err_req    = !legal || (misaligned && !MISALIGN_EN);
      if (!misaligned) begin
         beats_req = 3'd1;
      end else if (req_funct3[1:0] == 2'b01) begin
         beats_req = 3'd2;
      end else begin
         beats_req = 3'd4;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = err_req ? StResp : StAccess;
            end
         end
         StAccess: begin
            if (beat_fire && last_beat) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Request latch, beat counter and load assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         split_q  <= 1'b0;
         err_q    <= 1'b0;
         beats_q  <= '0;
         idx_q    <= '0;
         asm_q    <= '0;
      end else if (accept) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
         split_q  <= misaligned && !err_req;
         err_q    <= err_req;
         beats_q  <= beats_req;
         idx_q    <= '0;
         asm_q    <= '0;
      end else if (beat_fire) begin
         idx_q <= idx_q + 3'd1;
         if (!we_q) begin
            if (split_q) begin
               asm_q[{idx_q[1:0], 3'b000} +: 8] <= mem_rdata[7:0];
            end else begin
               asm_q <= mem_rdata;
            end
         end
      end
   end

   // Aligned loads are already extended by the memory; split halfwords are extended here.
   always_comb begin
      load_result = asm_q;
      if (split_q) begin
         case (funct3_q)
            F3H:     load_result = {{16{asm_q[15]}}, asm_q[15:0]};
            F3HU:    load_result = {16'h0000, asm_q[15:0]};
            default: load_result = asm_q;
         endcase
      end
   end

   // Outputs.
   always_comb begin
      req_ready  = 1'b0;
      stall      = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_addr   = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_funct3 = '0;
      mem_wdata  = '0;
      unique case (state_q)
         StIdle: req_ready = 1'b1;
         StAccess: begin
            stall = 1'b1;
            if (!fetch_slot) begin
               mem_read  = !we_q;
               mem_write = we_q;
               if (split_q) begin
                  mem_addr   = addr_q + ADDR_W'(idx_q);
                  mem_funct3 = we_q ? F3B : F3BU;
                  mem_wdata  = {24'h000000, wdata_q[{idx_q[1:0], 3'b000} +: 8]};
               end else begin
                  mem_addr   = addr_q;
                  mem_funct3 = funct3_q;
                  mem_wdata  = wdata_q;
               end
            end
         end
         StResp: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || we_q) ? 32'h0 : load_result;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_align_sequencer.sv
// Scoreboard bench for lsu_align_sequencer: a byte-memory model, expected beats/responses
// queued at issue time and compared by a negedge monitor.
module tb_lsu_align_sequencer;

   localparam int AW = 9;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [2:0]    f3;
      logic [31:0]   wd;
      logic          split;
   } beat_t;

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          lat;
   } resp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          fetch_slot, req_valid, req_ready, req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid, resp_err, stall;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_read, mem_write;
   logic [2:0]    mem_funct3;
   logic [31:0]   mem_wdata, mem_rdata;

   logic          req_valid2, req_ready2, req_we2;
   logic [2:0]    req_funct32;
   logic [AW-1:0] req_addr2;
   logic          resp_valid2, resp_err2, stall2;
   logic [31:0]   resp_rdata2;
   logic [AW-1:0] mem_addr2;
   logic          mem_read2, mem_write2;
   logic [2:0]    mem_funct32;
   logic [31:0]   mem_wdata2, mem_rdata2;

   lsu_align_sequencer #(.ADDR_W(AW), .MISALIGN_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .fetch_slot(fetch_slot),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   lsu_align_sequencer #(.ADDR_W(AW), .MISALIGN_EN(1'b0)) dut2 (
      .clk(clk), .rst(rst), .fetch_slot(1'b0),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
      .req_funct3(req_funct32), .req_addr(req_addr2), .req_wdata(32'h0),
      .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2), .stall(stall2),
      .mem_addr(mem_addr2), .mem_read(mem_read2), .mem_write(mem_write2),
      .mem_funct3(mem_funct32), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
   );

   assign mem_rdata2 = mem_read2 ? 32'h12345678 : 32'hBAD0BAD0;

   // Byte memory model with funct3-driven extension on reads.
   logic [7:0]    mem [512];
   logic [AW-1:0] ma1, ma2, ma3;
   assign ma1 = mem_addr + AW'(1);
   assign ma2 = mem_addr + AW'(2);
   assign ma3 = mem_addr + AW'(3);

   function automatic logic [31:0] memrd(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b010:  return w;
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   assign mem_rdata = mem_read ? memrd(mem_funct3, {mem[ma3], mem[ma2], mem[ma1], mem[mem_addr]})
                               : 32'hBAD0BAD0;

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr] <= mem_wdata[7:0];
         if (mem_funct3 != 3'b000) mem[ma1] <= mem_wdata[15:8];
         if (mem_funct3 == 3'b010) begin
            mem[ma2] <= mem_wdata[23:16];
            mem[ma3] <= mem_wdata[31:24];
         end
      end
   end

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int acc_cyc = 0;
   beat_t bq[$];
   resp_t rq[$];
   beat_t mb;
   resp_t mr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic fail(input string nm);
      n_chk++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Monitor: every memory access and every response is checked against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_read || mem_write) begin
            chk("mem_rw_excl", 32'(mem_read & mem_write), 32'd0);
            chk("mem_in_fetch", 32'(fetch_slot), 32'd0);
            chk("stall_in_access", 32'(stall), 32'd1);
            if (bq.size() == 0) begin
               fail("unexpected_mem_access");
            end else begin
               mb = bq.pop_front();
               chk("beat_we", 32'(mem_write), 32'(mb.we));
               chk("beat_addr", 32'(mem_addr), 32'(mb.addr));
               chk("beat_funct3", 32'(mem_funct3), 32'(mb.f3));
               if (mb.we) chk("beat_wdata", mb.split ? {24'h0, mem_wdata[7:0]} : mem_wdata, mb.wd);
            end
         end
         if (resp_valid) begin
            if (rq.size() == 0) begin
               fail("unexpected_resp");
            end else begin
               mr = rq.pop_front();
               chk("resp_err", 32'(resp_err), 32'(mr.err));
               chk("resp_rdata", resp_rdata, mr.rd);
               chk("latency", 32'(cyc - acc_cyc + 1), 32'(mr.lat));
               chk("resp_stall_low", 32'(stall), 32'd0);
               chk("resp_ready_low", 32'(req_ready), 32'd0);
               if (bq.size() != 0) fail("beats_left_at_resp");
            end
         end
      end
   end

   task automatic push_beats(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                             input logic [31:0] wd);
      beat_t b;
      int    n;
      logic  mis;
      mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
      if (!mis) begin
         b.we = we; b.addr = a; b.f3 = f3; b.wd = wd; b.split = 1'b0;
         bq.push_back(b);
      end else begin
         n = (f3[1:0] == 2'b01) ? 2 : 4;
         for (int i = 0; i < n; i++) begin
            b.we    = we;
            b.addr  = a + AW'(i);
            b.f3    = we ? 3'b000 : 3'b100;
            b.wd    = (wd >> (8 * i)) & 32'hFF;
            b.split = 1'b1;
            bq.push_back(b);
         end
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] rd,
                        input int lat, input logic tog);
      resp_t r;
      int    n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) fail("ready_timeout");
      if (!err) push_beats(we, f3, a, wd);
      r.err = err; r.rd = rd; r.lat = lat;
      rq.push_back(r);
      acc_cyc    = cyc;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      fetch_slot = tog;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = 32'h0;
      n = 0;
      while (rq.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         if (tog) fetch_slot = ~fetch_slot;
         n++;
      end
      fetch_slot = 1'b0;
      if (rq.size() != 0) begin
         fail("resp_timeout");
         rq.delete();
         bq.delete();
      end
   endtask

   int nresp;

   initial begin
      rst = 1'b1; fetch_slot = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'b000; req_addr = '0; req_wdata = 32'h0;
      req_valid2 = 1'b0; req_we2 = 1'b0; req_funct32 = 3'b000; req_addr2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      //    we    f3      addr      wdata         err   exp rdata      lat tog
      issue(1'b1, 3'b010, 9'h040, 32'hDEADBEEF, 1'b0, 32'h00000000, 3, 1'b0);
      issue(1'b0, 3'b010, 9'h040, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b0);
      issue(1'b1, 3'b010, 9'h041, 32'h11223344, 1'b0, 32'h00000000, 6, 1'b0);
      issue(1'b0, 3'b010, 9'h041, 32'h0,        1'b0, 32'h11223344, 6, 1'b0);
      issue(1'b0, 3'b100, 9'h043, 32'h0,        1'b0, 32'h00000022, 3, 1'b0);
      issue(1'b1, 3'b001, 9'h051, 32'h0000ABCD, 1'b0, 32'h00000000, 4, 1'b0);
      issue(1'b0, 3'b001, 9'h051, 32'h0,        1'b0, 32'hFFFFABCD, 4, 1'b0);
      issue(1'b0, 3'b101, 9'h051, 32'h0,        1'b0, 32'h0000ABCD, 4, 1'b0);
      issue(1'b1, 3'b001, 9'h060, 32'h00008001, 1'b0, 32'h00000000, 3, 1'b0);
      issue(1'b0, 3'b001, 9'h060, 32'h0,        1'b0, 32'hFFFF8001, 3, 1'b0);
      issue(1'b1, 3'b000, 9'h070, 32'h000000F0, 1'b0, 32'h00000000, 3, 1'b0);
      issue(1'b0, 3'b000, 9'h070, 32'h0,        1'b0, 32'hFFFFFFF0, 3, 1'b0);
      issue(1'b1, 3'b010, 9'h1FE, 32'hA1B2C3D4, 1'b0, 32'h00000000, 6, 1'b0);
      issue(1'b0, 3'b010, 9'h1FE, 32'h0,        1'b0, 32'hA1B2C3D4, 6, 1'b0);
      issue(1'b0, 3'b010, 9'h041, 32'h0,        1'b0, 32'h11223344, 10, 1'b1);
      issue(1'b0, 3'b011, 9'h040, 32'h0,        1'b1, 32'h00000000, 2, 1'b0);
      issue(1'b1, 3'b100, 9'h040, 32'h12345678, 1'b1, 32'h00000000, 2, 1'b0);
      issue(1'b0, 3'b110, 9'h041, 32'h0,        1'b1, 32'h00000000, 2, 1'b0);

      // MISALIGN_EN=0 instance: misaligned LW errors without access, aligned LW works.
      req_valid2 = 1'b1; req_we2 = 1'b0; req_funct32 = 3'b010; req_addr2 = 9'h042;
      @(negedge clk);
      chk("nomis_ready", 32'(req_ready2), 32'd1);
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      @(negedge clk);
      chk("nomis_resp_valid", 32'(resp_valid2), 32'd1);
      chk("nomis_resp_err", 32'(resp_err2), 32'd1);
      chk("nomis_resp_rdata", resp_rdata2, 32'd0);
      chk("nomis_no_access", {30'h0, mem_read2, mem_write2}, 32'd0);
      chk("nomis_stall", 32'(stall2), 32'd0);
      @(posedge clk); #1;
      req_valid2 = 1'b1; req_addr2 = 9'h040;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      @(negedge clk);
      chk("nomis_al_read", {30'h0, mem_read2, mem_write2}, 32'd2);
      chk("nomis_al_addr", 32'(mem_addr2), 32'h40);
      chk("nomis_al_stall", 32'(stall2), 32'd1);
      @(negedge clk);
      chk("nomis_al_resp", {31'h0, resp_valid2}, 32'd1);
      chk("nomis_al_rdata", resp_rdata2, 32'h12345678);
      chk("nomis_al_err", 32'(resp_err2), 32'd0);

      // Reset in the middle of a split load: no response afterwards.
      @(posedge clk); #1;
      push_beats(1'b0, 3'b100, 9'h041, 32'h0);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h041;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(req_ready), 32'd1);
      chk("midrst_stall", 32'(stall), 32'd0);
      chk("midrst_mem_read", 32'(mem_read), 32'd0);
      chk("midrst_beats_seen", 32'(bq.size()), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bq.delete();
      nresp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) nresp++;
      end
      chk("midrst_no_resp", 32'(nresp), 32'd0);
      chk("midrst_idle_ready", 32'(req_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
